// File: rtl/cook_stage_sequencer_if.sv
// cook_stage_sequencer_if
// Groups every non-clock/reset signal of the cooking stage sequencer.
//   master : front-panel control FSM plus timer side (drives cfg_*, run,
//            abort, hold, tmr_done; observes the rest)
//   slave  : the sequencer itself
// Signalling: there is no valid/ready pair on this bus. cfg_we, run, abort
// and tmr_done are single-cycle strobes sampled on the rising clock edge;
// hold is a level. tmr_load, tmr_start, tmr_stop, finished and cfg_err are
// one-cycle pulses; tmr_pause is a level. No strobe is ever back-pressured:
// a strobe that is not legal in the current state is simply dropped.
// dbg_state exposes the sequencer state register for checkers.
interface cook_stage_sequencer_if #(
    parameter int IDX_W = 2
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [6:0]       cfg_min;
    logic [6:0]       cfg_sec;
    logic [1:0]       cfg_pot;
    logic             run;
    logic             abort;
    logic             hold;
    logic             tmr_done;
    logic             tmr_load;
    logic             tmr_start;
    logic             tmr_stop;
    logic             tmr_pause;
    logic [6:0]       tmr_min;
    logic [6:0]       tmr_sec;
    logic [1:0]       potencia;
    logic [IDX_W-1:0] stage;
    logic             busy;
    logic             finished;
    logic             cfg_err;
    logic [2:0]       dbg_state;

    modport master (
        output cfg_we, cfg_idx, cfg_min, cfg_sec, cfg_pot,
        output run, abort, hold, tmr_done,
        input  tmr_load, tmr_start, tmr_stop, tmr_pause, tmr_min, tmr_sec,
        input  potencia, stage, busy, finished, cfg_err, dbg_state
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_min, cfg_sec, cfg_pot,
        input  run, abort, hold, tmr_done,
        output tmr_load, tmr_start, tmr_stop, tmr_pause, tmr_min, tmr_sec,
        output potencia, stage, busy, finished, cfg_err, dbg_state
    );
endinterface

// File: rtl/cook_stage_sequencer.sv
// cook_stage_sequencer
// Steps through a table of cooking stages {min, sec, pot}. On run it loads
// each stage into the countdown timer, starts it and waits for the timer's
// done pulse before advancing; zero-time stages are skipped, pot=0 ends the
// program. Hold pauses the timer and cuts power; abort clears the timer.
// Ports:
//   clock  : system clock
//   reset  : asynchronous, active-high; clears state, index and table
//   bus    : cook_stage_sequencer_if.slave (config, control, timer, status)
// All outputs except cfg_err are decoded from the registered state, index
// and table; cfg_err is a registered one-cycle pulse.
module cook_stage_sequencer #(
    parameter int N_STAGES = 4,
    parameter int IDX_W    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    cook_stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_COOK, S_HOLD, S_NEXT, S_FINISH, S_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nx;
    logic [6:0]       tab_min [N_STAGES];
    logic [6:0]       tab_sec [N_STAGES];
    logic [1:0]       tab_pot [N_STAGES];
    logic             cfg_ok;
    logic             wr_en;
    logic             cfg_err_q, cfg_err_d;

    assign idx_nx = idx_q + IDX_W'(1);
    assign cfg_ok = (bus.cfg_min <= 7'd99) && (bus.cfg_sec <= 7'd59);
    assign wr_en  = (state_q == S_IDLE) && bus.cfg_we && cfg_ok;

    // Rejected write or run on an empty program; both only matter in IDLE.
    assign cfg_err_d = (state_q == S_IDLE) &&
                       ((bus.cfg_we && !cfg_ok) || (bus.run && tab_pot[0] == 2'd0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < N_STAGES; i++) begin
                tab_min[i] <= '0;
                tab_sec[i] <= '0;
                tab_pot[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cfg_err_q <= cfg_err_d;
            if (wr_en) begin
                tab_min[bus.cfg_idx] <= bus.cfg_min;
                tab_sec[bus.cfg_idx] <= bus.cfg_sec;
                tab_pot[bus.cfg_idx] <= bus.cfg_pot;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run && !bus.hold && tab_pot[0] != 2'd0) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = bus.abort ? S_ABORT : S_START;
            S_START: state_d = bus.abort ? S_ABORT : S_COOK;
            S_COOK: begin
                if (bus.abort)         state_d = S_ABORT;
                else if (bus.tmr_done) state_d = S_NEXT;
                else if (bus.hold)     state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.abort)         state_d = S_ABORT;
                else if (bus.tmr_done) state_d = S_NEXT;
                else if (!bus.hold)    state_d = S_COOK;
            end
            S_NEXT: begin
                if (bus.abort) begin
                    state_d = S_ABORT;
                end else if (idx_q == IDX_W'(N_STAGES - 1) || tab_pot[idx_nx] == 2'd0) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_nx;
                    // A zero-time stage costs one NEXT cycle and is never loaded.
                    if (tab_min[idx_nx] == 7'd0 && tab_sec[idx_nx] == 7'd0)
                        state_d = S_NEXT;
                    else
                        state_d = S_LOAD;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.tmr_load  = (state_q == S_LOAD);
    assign bus.tmr_start = (state_q == S_START);
    assign bus.tmr_stop  = (state_q == S_ABORT);
    assign bus.tmr_pause = (state_q == S_HOLD);
    assign bus.finished  = (state_q == S_FINISH);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.potencia  = (state_q == S_LOAD || state_q == S_START || state_q == S_COOK)
                           ? tab_pot[idx_q] : 2'd0;
    assign bus.tmr_min   = tab_min[idx_q];
    assign bus.tmr_sec   = tab_sec[idx_q];
    assign bus.stage     = idx_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_cook_stage_sequencer.sv
// tb_cook_stage_sequencer
// Self-checking bench for cook_stage_sequencer: reset values, a table of
// configuration-write vectors, hand-written multi-cycle sequences (single
// stage, zero-time skip, hold, abort/done collision, reset mid-program) and
// randomized programs checked against a stage-list model.
module tb_cook_stage_sequencer;
    localparam int IDX_W = 2;
    localparam int N     = 4;
    localparam int W     = 18;  // {stage, min, sec, pot} of one timer load

    logic clock;
    logic reset;

    cook_stage_sequencer_if #(.IDX_W(IDX_W)) bus ();

    cook_stage_sequencer #(.N_STAGES(N), .IDX_W(IDX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;
    int load_cnt = 0, start_cnt = 0, fin_cnt = 0;

    always @(negedge clock) begin
        if (bus.tmr_load)  load_cnt++;
        if (bus.tmr_start) start_cnt++;
        if (bus.finished)  fin_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [1:0] i, input logic [6:0] mn,
                      input logic [6:0] sc, input logic [1:0] pt);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = i;
        bus.cfg_min = mn;
        bus.cfg_sec = sc;
        bus.cfg_pot = pt;
        tick();
        bus.cfg_we  = 1'b0;
    endtask

    task automatic pulse_run();
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
    endtask

    task automatic pulse_done();
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"},  bus.tmr_load, 0);
        check({tag, "_start"}, bus.tmr_start, 0);
        check({tag, "_stop"},  bus.tmr_stop, 0);
        check({tag, "_pause"}, bus.tmr_pause, 0);
        check({tag, "_min"},   bus.tmr_min, 0);
        check({tag, "_sec"},   bus.tmr_sec, 0);
        check({tag, "_pot"},   bus.potencia, 0);
        check({tag, "_stage"}, bus.stage, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_fin"},   bus.finished, 0);
        check({tag, "_err"},   bus.cfg_err, 0);
    endtask

    // ---------------- config-write vectors ----------------
    typedef struct {
        logic [1:0] idx;
        logic [6:0] mn;
        logic [6:0] sc;
        logic [1:0] pt;
        logic       exp_err;
        logic [6:0] exp_min;  // entry0 as seen on tmr_min while idx=0
        logic [6:0] exp_sec;
    } cfg_vec_t;

    cfg_vec_t vecs[8];

    // ---------------- model / scoreboard ----------------
    logic [6:0] m_min [N];
    logic [6:0] m_sec [N];
    logic [1:0] m_pot [N];
    logic [W-1:0] exp_q[$];

    initial begin
        int l0, s0, f0;
        logic [W-1:0] got, exp;
        logic [6:0] mn, sc;
        logic [1:0] pt;
        int fin, armed, cook_left, cyc;

        vecs[0] = '{2'd0, 7'd1,   7'd30,  2'd2, 1'b0, 7'd1,  7'd30};
        vecs[1] = '{2'd0, 7'd5,   7'd60,  2'd1, 1'b1, 7'd1,  7'd30};
        vecs[2] = '{2'd0, 7'd100, 7'd0,   2'd3, 1'b1, 7'd1,  7'd30};
        vecs[3] = '{2'd1, 7'd7,   7'd7,   2'd1, 1'b0, 7'd1,  7'd30};
        vecs[4] = '{2'd0, 7'd99,  7'd59,  2'd3, 1'b0, 7'd99, 7'd59};
        vecs[5] = '{2'd0, 7'd127, 7'd127, 2'd3, 1'b1, 7'd99, 7'd59};
        vecs[6] = '{2'd0, 7'd0,   7'd59,  2'd1, 1'b0, 7'd0,  7'd59};
        vecs[7] = '{2'd0, 7'd1,   7'd30,  2'd2, 1'b0, 7'd1,  7'd30};

        bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_min = 0; bus.cfg_sec = 0;
        bus.cfg_pot = 0; bus.run = 0; bus.abort = 0; bus.hold = 0; bus.tmr_done = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        tick();

        // ---- table-driven configuration writes ----
        for (int v = 0; v < 8; v++) begin
            wr(vecs[v].idx, vecs[v].mn, vecs[v].sc, vecs[v].pt);
            check($sformatf("vec%0d_err", v), bus.cfg_err, vecs[v].exp_err);
            check($sformatf("vec%0d_min", v), bus.tmr_min, vecs[v].exp_min);
            check($sformatf("vec%0d_sec", v), bus.tmr_sec, vecs[v].exp_sec);
            tick();
            check($sformatf("vec%0d_err_clr", v), bus.cfg_err, 0);
        end

        // ---- single stage {1,30,2} ----
        wr(2'd1, 7'd0, 7'd0, 2'd0);
        pulse_run();
        check("s1_load", bus.tmr_load, 1);
        check("s1_min", bus.tmr_min, 1);
        check("s1_sec", bus.tmr_sec, 30);
        check("s1_pot_load", bus.potencia, 2);
        check("s1_busy", bus.busy, 1);
        tick();
        check("s1_start", bus.tmr_start, 1);
        check("s1_load_off", bus.tmr_load, 0);
        tick();
        check("s1_cook_pot", bus.potencia, 2);
        check("s1_cook_start_off", bus.tmr_start, 0);
        pulse_done();
        check("s1_next_pot", bus.potencia, 0);
        check("s1_next_fin", bus.finished, 0);
        tick();
        check("s1_finished", bus.finished, 1);
        tick();
        check("s1_fin_off", bus.finished, 0);
        check("s1_idle", bus.busy, 0);

        // ---- three stages, zero-time middle, hold in the last stage ----
        wr(2'd0, 7'd0, 7'd20, 2'd3);
        wr(2'd1, 7'd0, 7'd0,  2'd1);
        wr(2'd2, 7'd2, 7'd0,  2'd1);
        wr(2'd3, 7'd0, 7'd0,  2'd0);
        l0 = load_cnt; s0 = start_cnt; f0 = fin_cnt;
        pulse_run();
        check("m_load0_stage", bus.stage, 0);
        check("m_load0_sec", bus.tmr_sec, 20);
        check("m_load0_pot", bus.potencia, 3);
        tick(); tick();
        pulse_done();
        tick();
        check("m_skip_load", bus.tmr_load, 0);
        check("m_skip_pot", bus.potencia, 0);
        tick();
        check("m_load2", bus.tmr_load, 1);
        check("m_load2_stage", bus.stage, 2);
        check("m_load2_min", bus.tmr_min, 2);
        check("m_load2_pot", bus.potencia, 1);
        tick(); tick();
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("h_pause%0d", i), bus.tmr_pause, 1);
            check($sformatf("h_pot%0d", i), bus.potencia, 0);
        end
        bus.hold = 1'b0;
        tick();
        check("h_release_pause", bus.tmr_pause, 0);
        check("h_release_pot", bus.potencia, 1);
        tick();
        check("h_no_reload", load_cnt - l0, 2);
        check("h_no_restart", start_cnt - s0, 2);
        pulse_done();
        tick();
        check("m_finished", bus.finished, 1);
        tick();
        check("m_idle", bus.busy, 0);
        check("m_load_total", load_cnt - l0, 2);
        check("m_fin_count", fin_cnt - f0, 1);

        // ---- abort and done in the same cycle ----
        f0 = fin_cnt;
        pulse_run();
        tick(); tick();
        bus.abort = 1'b1; bus.tmr_done = 1'b1;
        tick();
        bus.abort = 1'b0; bus.tmr_done = 1'b0;
        check("ab_stop", bus.tmr_stop, 1);
        check("ab_fin", bus.finished, 0);
        tick();
        check("ab_idle", bus.busy, 0);
        check("ab_stop_off", bus.tmr_stop, 0);
        tick();
        check("ab_no_finished", fin_cnt - f0, 0);

        // ---- reset mid-program at stage 1 ----
        wr(2'd0, 7'd0, 7'd5, 2'd1);
        wr(2'd1, 7'd0, 7'd9, 2'd2);
        wr(2'd2, 7'd0, 7'd0, 2'd0);
        pulse_run();
        tick(); tick();
        pulse_done();
        tick(); tick(); tick();
        check("r_stage1", bus.stage, 1);
        check("r_pot1", bus.potencia, 2);
        check("r_sec1", bus.tmr_sec, 9);
        reset = 1'b1;
        #1;
        check_all_zero("r_async");
        @(negedge clock);
        reset = 1'b0;
        tick();
        pulse_run();
        check("r_run_empty_err", bus.cfg_err, 1);
        check("r_run_empty_busy", bus.busy, 0);
        tick();
        check("r_err_clr", bus.cfg_err, 0);
        check("r_still_idle", bus.busy, 0);

        // ---- randomized programs against the stage-list model ----
        for (int i = 0; i < N; i++) begin
            m_min[i] = '0; m_sec[i] = '0; m_pot[i] = '0;
        end
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin
                        mn = 7'($urandom_range(0, 99));
                        sc = 7'($urandom_range(60, 127));
                    end else begin
                        mn = 7'($urandom_range(100, 127));
                        sc = 7'($urandom_range(0, 59));
                    end
                    wr(2'(i), mn, sc, 2'($urandom_range(0, 3)));
                    check("rnd_bad_wr_err", bus.cfg_err, 1);
                end
                if (i == 0) pt = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                else        pt = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) begin
                    mn = 7'd0; sc = 7'd0;
                end else begin
                    mn = 7'($urandom_range(0, 99));
                    sc = 7'($urandom_range(0, 59));
                end
                wr(2'(i), mn, sc, pt);
                check("rnd_wr_err", bus.cfg_err, 0);
                m_min[i] = mn; m_sec[i] = sc; m_pot[i] = pt;
            end
            tick();

            // Expected timer loads: stage 0 always, then every following
            // non-zero-time stage until the first pot=0 entry.
            exp_q.delete();
            if (m_pot[0] != 2'd0) begin
                exp_q.push_back({2'd0, m_min[0], m_sec[0], m_pot[0]});
                for (int i = 1; i < N; i++) begin
                    if (m_pot[i] == 2'd0) break;
                    if (m_min[i] != 7'd0 || m_sec[i] != 7'd0)
                        exp_q.push_back({2'(i), m_min[i], m_sec[i], m_pot[i]});
                end
            end

            if (m_pot[0] == 2'd0) begin
                pulse_run();
                check("rnd_empty_err", bus.cfg_err, 1);
                check("rnd_empty_busy", bus.busy, 0);
                tick();
                continue;
            end

            pulse_run();
            fin = 0; armed = 0; cook_left = 0; cyc = 0;
            while (fin == 0 && cyc < 400) begin
                if (bus.tmr_load) begin
                    got = {bus.stage, bus.tmr_min, bus.tmr_sec, bus.potencia};
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check("rnd_load", got, exp);
                end
                if (bus.tmr_pause) check("rnd_pause_pot", bus.potencia, 0);
                if (bus.finished) begin
                    fin = 1;
                    check("rnd_drained", exp_q.size(), 0);
                end
                bus.tmr_done = 1'b0;
                if (bus.tmr_start) begin
                    armed = 1;
                    cook_left = $urandom_range(0, 6);
                end else if (armed != 0) begin
                    if (cook_left == 0) begin
                        bus.tmr_done = 1'b1;
                        bus.hold = 1'b0;
                        armed = 0;
                    end else begin
                        cook_left--;
                        bus.hold = ($urandom_range(0, 3) == 0);
                    end
                end
                tick();
                cyc++;
            end
            bus.tmr_done = 1'b0;
            bus.hold = 1'b0;
            check("rnd_finished", fin, 1);
            check("rnd_idle", bus.busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
